// File: rtl/noc_pkg.sv
// Shared widths, default parameters and packet helpers for the PE network interface.
// A packet is {dest, data}; the destination sits directly above the payload.
package noc_pkg;

  localparam int NUM_PE     = 16;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 32;
  localparam int TOTAL_W    = ADDR_W + DATA_W;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 32;

  // Receive-side round-robin pointer: which requester wins the next contested grant.
  typedef enum logic {
    RR_NET = 1'b0,
    RR_LB  = 1'b1
  } rr_sel_e;

  function automatic logic [ADDR_W-1:0] get_dest(input logic [TOTAL_W-1:0] pkt);
    return ADDR_W'(pkt >> DATA_W);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO, power-of-two depth, head visible combinationally on data_o.
// Push is ignored when full and pop is ignored when empty, so occupancy stays in range.
module sync_fifo
  import noc_pkg::*;
#(
  parameter  int Width = TOTAL_W,
  parameter  int Depth = FIFO_DEPTH,
  localparam int PtrW  = $clog2(Depth),
  localparam int CntW  = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read while count is zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pe_net_if.sv
// PE-to-network interface: inject FIFO steering packets to the switch, loopback or drop,
// plus a round-robin receive arbiter feeding a one-entry output register towards the PE.
module pe_net_if
  import noc_pkg::*;
#(
  parameter int address      = 0,
  parameter int numPE        = NUM_PE,
  parameter int AddressWidth = ADDR_W,
  parameter int DataWidth    = DATA_W,
  parameter int TotalWidth   = TOTAL_W,
  parameter int FifoDepth    = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TotalWidth-1:0] pe_i_data,
  input  logic                  pe_i_data_valid,
  output logic                  pe_o_data_ready,
  output logic [TotalWidth-1:0] pe_o_data,
  output logic                  pe_o_data_valid,
  input  logic                  pe_i_data_ready,
  output logic [TotalWidth-1:0] net_o_data,
  output logic                  net_o_data_valid,
  input  logic                  net_i_data_ready,
  input  logic [TotalWidth-1:0] net_i_data,
  input  logic                  net_i_data_valid,
  output logic                  net_o_data_ready,
  output logic [CNT_W-1:0]      sent_cnt,
  output logic [CNT_W-1:0]      recv_cnt,
  output logic [CNT_W-1:0]      loop_cnt,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int FifoCntW = $clog2(FifoDepth) + 1;

  logic [TotalWidth-1:0]   head;
  logic [AddressWidth-1:0] head_dest;
  logic                    fifo_full, fifo_empty;
  logic                    fifo_push, fifo_pop;
  logic [FifoCntW-1:0]     fifo_count;
  logic                    fifo_count_unused;
  logic                    head_drop, head_loop, head_net;
  logic                    lb_req, drop_pop, net_tx;
  logic                    out_can_load, grant_net, grant_lb;
  rr_sel_e                 rr_q, rr_d;
  logic                    out_vld_q, out_vld_d;
  logic [TotalWidth-1:0]   out_dat_q, out_dat_d;
  logic [CNT_W-1:0]        sent_q, sent_d;
  logic [CNT_W-1:0]        recv_q, recv_d;
  logic [CNT_W-1:0]        loop_q, loop_d;
  logic [CNT_W-1:0]        drop_q, drop_d;

  // ---------------------------------------------------------------- inject side
  assign pe_o_data_ready   = rst && !fifo_full;
  assign fifo_push         = pe_i_data_valid && pe_o_data_ready;
  assign fifo_count_unused = ^fifo_count;

  sync_fifo #(
    .Width (TotalWidth),
    .Depth (FifoDepth)
  ) u_inject_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (fifo_push),
    .data_i  (pe_i_data),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  if (AddressWidth == ADDR_W && DataWidth == DATA_W && TotalWidth == TOTAL_W) begin : g_pkg_dest
    assign head_dest = get_dest(head);
  end else begin : g_slice_dest
    assign head_dest = head[DataWidth +: AddressWidth];
  end

  // Out-of-range destinations are discarded before the own-address check.
  assign head_drop = (32'(head_dest) >= 32'(numPE));
  assign head_loop = !head_drop && (32'(head_dest) == 32'(address));
  assign head_net  = !head_drop && !head_loop;

  assign net_o_data_valid = !fifo_empty && head_net;
  assign net_o_data       = net_o_data_valid ? head : '0;
  assign lb_req           = !fifo_empty && head_loop;
  assign drop_pop         = !fifo_empty && head_drop;
  assign net_tx           = net_o_data_valid && net_i_data_ready;
  assign fifo_pop         = net_tx || grant_lb || drop_pop;

  // ---------------------------------------------------------------- receive side
  always_comb begin
    out_can_load = !out_vld_q || pe_i_data_ready;
    grant_net    = 1'b0;
    grant_lb     = 1'b0;
    rr_d         = rr_q;
    if (out_can_load) begin
      if (net_i_data_valid && lb_req) begin
        grant_net = (rr_q == RR_NET);
        grant_lb  = (rr_q == RR_LB);
        rr_d      = (rr_q == RR_NET) ? RR_LB : RR_NET;
      end else begin
        grant_net = net_i_data_valid;
        grant_lb  = lb_req;
      end
    end
  end

  assign net_o_data_ready = grant_net;

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (out_vld_q && pe_i_data_ready) out_vld_d = 1'b0;
    if (grant_net) begin
      out_vld_d = 1'b1;
      out_dat_d = net_i_data;
    end else if (grant_lb) begin
      out_vld_d = 1'b1;
      out_dat_d = head;
    end
  end

  assign pe_o_data       = out_dat_q;
  assign pe_o_data_valid = out_vld_q;

  // ---------------------------------------------------------------- statistics
  always_comb begin
    sent_d = sent_q + CNT_W'(net_tx);
    recv_d = recv_q + CNT_W'(grant_net);
    loop_d = loop_q + CNT_W'(grant_lb);
    drop_d = drop_q + CNT_W'(drop_pop);
  end

  assign sent_cnt = sent_q;
  assign recv_cnt = recv_q;
  assign loop_cnt = loop_q;
  assign drop_cnt = drop_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q      <= RR_NET;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      sent_q    <= '0;
      recv_q    <= '0;
      loop_q    <= '0;
      drop_q    <= '0;
    end else begin
      rr_q      <= rr_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      sent_q    <= sent_d;
      recv_q    <= recv_d;
      loop_q    <= loop_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: doc/pe_net_if.md
PE_NET_IF -- requirements
Module: pe_net_if

Interface
REQ-001 Parameters SHALL be: address, 0, own PE index; numPE, 16, PEs in network; AddressWidth, 4, destination field width; DataWidth, 32, payload width; TotalWidth, 36, packet width {dest,data}; FifoDepth, 4, inject FIFO entries (power of 2, >=2).
REQ-002 clk  in  1  single clock, all logic on posedge.
REQ-003 rst  in  1  synchronous reset, active-low.
REQ-004 pe_i_data  in  TotalWidth  packet from PE; pe_i_data_valid  in  1; pe_o_data_ready  out  1.
REQ-005 pe_o_data  out  TotalWidth  packet to PE; pe_o_data_valid  out  1; pe_i_data_ready  in  1.
REQ-006 net_o_data  out  TotalWidth  packet to switch; net_o_data_valid  out  1; net_i_data_ready  in  1.
REQ-007 net_i_data  in  TotalWidth  packet from switch; net_i_data_valid  in  1; net_o_data_ready  out  1.
REQ-008 sent_cnt, recv_cnt, loop_cnt, drop_cnt  out  32 each  packets to network, from network, looped back, dropped.

Function
REQ-009 Any port SHALL transfer exactly when valid and ready are both high at posedge clk; valid and data SHALL be held until transfer.
REQ-010 PE packets SHALL enter a FifoDepth-entry inject FIFO; pe_o_data_ready SHALL equal not-full, with no push-bypass when full.
REQ-011 Head destination SHALL be head[DataWidth +: AddressWidth].
REQ-012 Head with destination != address and < numPE: net_o_data = head, net_o_data_valid = not-empty; pop and sent_cnt+1 on net handshake.
REQ-013 Head with destination == address SHALL be a loopback request to the receive arbiter; pop and loop_cnt+1 on grant.
REQ-014 Head with destination >= numPE SHALL be popped in one cycle without output, drop_cnt+1.
REQ-015 FIFO is in-order; a blocked head (either path) SHALL stall all entries behind it.
REQ-016 Push-to-net_o_data_valid latency SHALL be 1 cycle when FIFO was empty.
REQ-017 Receive side: one-entry output register driving pe_o_data/pe_o_data_valid; loads when empty or being consumed the same cycle.
REQ-018 Arbiter: two requesters (net ingress, loopback), round-robin; pointer toggles only after a grant while both requested; uncontested requester granted immediately.
REQ-019 net_o_data_ready SHALL be high only when the net ingress is granted and the output register can load.
REQ-020 Net ingress to pe_o_data_valid latency SHALL be 1 cycle; recv_cnt+1 per net handshake.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; occupancy SHALL never exceed FifoDepth or go below 0.
REQ-022 Counters SHALL wrap modulo 2^32.

Reset
REQ-023 While rst==0 at posedge: FIFO empty, pointers 0, all valids 0, pe_o_data and net_o_data 0, counters 0, arbiter pointer to net.
REQ-024 Reset mid-operation SHALL discard all buffered and in-flight packets without counting them; pe_o_data_ready SHALL be 0 during reset and 1 on the first cycle after release.

Structure
REQ-025 Widths, default parameters and a dest-extract function SHALL live in shared package noc_pkg.
REQ-026 Inject FIFO SHALL be sub-module sync_fifo (parameterised width/depth, full/empty/count outputs); arbiter and output register inline.

Verification
REQ-027 Single send: address=3, PE pushes {4'd7,32'd5} -> net_o_data=0x700000005, valid next cycle, sent_cnt=1 after handshake.
REQ-028 Backpressure: net_i_data_ready=0, 5 pushes with FifoDepth=4 -> pe_o_data_ready=0 after 4th; release -> 4 packets out in order, then 5th accepted.
REQ-029 Loopback: address=3, push {4'd3,32'd9} with switch idle -> pe_o_data=0x300000009 two cycles after push, loop_cnt=1, net_o_data_valid stays 0.
REQ-030 Contention: net ingress and loopback valid every cycle for 8 cycles, pe_i_data_ready=1 -> grants alternate, 4 each, starting with net.
REQ-031 Reset mid-traffic: 3 entries buffered, rst=0 one cycle -> all valids 0, counters 0, no buffered packet appears after release.
REQ-032 Drop: numPE=8, push {4'd12,32'd1} -> no output on any port, drop_cnt=1, FIFO empty one cycle after reaching head.
